// File: rtl/prescaled_counter_if.sv
// Control and status bundle for prescaled_counter: count/load controls in, count value and
// step pulses out.
interface prescaled_counter_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic             count;
    logic             up_down;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic [WIDTH-1:0] Q;
    logic             tick;
    logic             wrap;
    logic             terminal;

    modport master (
        output count, up_down, load, load_value,
        input  Q, tick, wrap, terminal
    );

    modport slave (
        input  count, up_down, load, load_value,
        output Q, tick, wrap, terminal
    );
endinterface

// File: rtl/prescaled_counter.sv
// Up/down counter that steps once every CYCLES_PER_TICK enabled clocks, with synchronous load
// and optional saturation at the limits.
module prescaled_counter #(
    parameter int unsigned WIDTH           = 8,
    parameter int unsigned CYCLES_PER_TICK = 500,
    parameter bit          SATURATE        = 1'b0
) (
    input logic                clock,
    input logic                clear_n,
    prescaled_counter_if.slave bus
);

    localparam int unsigned     PreW    = (CYCLES_PER_TICK > 1) ? $clog2(CYCLES_PER_TICK) : 1;
    localparam logic [PreW-1:0] PreMax  = PreW'(CYCLES_PER_TICK - 1);
    localparam logic [WIDTH-1:0] AllOnes = '1;

    logic [PreW-1:0]  pre_q;
    logic [WIDTH-1:0] q_q;
    logic             tick_q;
    logic             wrap_q;

    logic             at_limit;
    logic [WIDTH-1:0] q_step;
    logic             step_wraps;

    // Limit is judged against the live direction so terminal reacts without a clock edge.
    always_comb begin
        at_limit = bus.up_down ? (q_q == AllOnes) : (q_q == '0);
    end

    always_comb begin
        q_step     = q_q;
        step_wraps = 1'b0;
        if (at_limit) begin
            if (!SATURATE) begin
                q_step     = bus.up_down ? '0 : AllOnes;
                step_wraps = 1'b1;
            end
        end else begin
            q_step = bus.up_down ? (q_q + 1'b1) : (q_q - 1'b1);
        end
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            pre_q  <= '0;
            q_q    <= '0;
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
        end else if (bus.load) begin
            pre_q  <= '0;
            q_q    <= bus.load_value;
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
        end else if (bus.count) begin
            if (pre_q == PreMax) begin
                pre_q  <= '0;
                q_q    <= q_step;
                tick_q <= 1'b1;
                wrap_q <= step_wraps;
            end else begin
                pre_q  <= pre_q + 1'b1;
                tick_q <= 1'b0;
                wrap_q <= 1'b0;
            end
        end else begin
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
        end
    end

    assign bus.Q        = q_q;
    assign bus.tick     = tick_q;
    assign bus.wrap     = wrap_q;
    assign bus.terminal = at_limit;

endmodule

// File: tb/tb_prescaled_counter.sv
// Drives three counter configurations (prescale 4 wrap, prescale 4 saturate, prescale 1 wrap)
// with shared stimulus and checks them against a scoreboard plus hand-computed scenarios.
module tb_prescaled_counter;

    logic       clock;
    logic       clear_n;
    logic       cnt, ud, ld;
    logic [7:0] lv;

    int n_checks;
    int n_fail;

    prescaled_counter_if #(.WIDTH(8)) ifa ();
    prescaled_counter_if #(.WIDTH(8)) ifb ();
    prescaled_counter_if #(.WIDTH(8)) ifc ();

    assign ifa.count = cnt;  assign ifa.up_down = ud;  assign ifa.load = ld;  assign ifa.load_value = lv;
    assign ifb.count = cnt;  assign ifb.up_down = ud;  assign ifb.load = ld;  assign ifb.load_value = lv;
    assign ifc.count = cnt;  assign ifc.up_down = ud;  assign ifc.load = ld;  assign ifc.load_value = lv;

    prescaled_counter #(.WIDTH(8), .CYCLES_PER_TICK(4), .SATURATE(1'b0)) dut_a (
        .clock(clock), .clear_n(clear_n), .bus(ifa)
    );
    prescaled_counter #(.WIDTH(8), .CYCLES_PER_TICK(4), .SATURATE(1'b1)) dut_b (
        .clock(clock), .clear_n(clear_n), .bus(ifb)
    );
    prescaled_counter #(.WIDTH(8), .CYCLES_PER_TICK(1), .SATURATE(1'b0)) dut_c (
        .clock(clock), .clear_n(clear_n), .bus(ifc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [7:0] q;
        logic       tick;
        logic       wrap;
        logic       term;
    } obs_t;

    typedef struct packed {
        logic       c;
        logic       u;
        logic       l;
        logic [7:0] v;
        logic [7:0] eq;
        logic       et;
        logic       ew;
        logic       eterm;
    } vec_t;

    obs_t        sb[$];
    vec_t        tbl[17];
    int unsigned cpt[3]  = '{4, 4, 1};
    bit          sat[3]  = '{1'b0, 1'b1, 1'b0};
    string       nm[3]   = '{"A", "B", "C"};
    logic [7:0]  m_q[3];
    int unsigned m_pre[3];
    logic        m_tick[3];
    logic        m_wrap[3];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_q[i] = 8'h00; m_pre[i] = 0; m_tick[i] = 1'b0; m_wrap[i] = 1'b0;
        end
    endtask

    task automatic model_step(input int i);
        if (ld) begin
            m_q[i] = lv; m_pre[i] = 0; m_tick[i] = 1'b0; m_wrap[i] = 1'b0;
        end else if (cnt) begin
            m_wrap[i] = 1'b0;
            if (m_pre[i] == cpt[i] - 1) begin
                m_pre[i]  = 0;
                m_tick[i] = 1'b1;
                if (ud) begin
                    if (m_q[i] != 8'hFF)  m_q[i] = m_q[i] + 8'd1;
                    else if (!sat[i])     begin m_q[i] = 8'h00; m_wrap[i] = 1'b1; end
                end else begin
                    if (m_q[i] != 8'h00)  m_q[i] = m_q[i] - 8'd1;
                    else if (!sat[i])     begin m_q[i] = 8'hFF; m_wrap[i] = 1'b1; end
                end
            end else begin
                m_pre[i]  = m_pre[i] + 1;
                m_tick[i] = 1'b0;
            end
        end else begin
            m_tick[i] = 1'b0; m_wrap[i] = 1'b0;
        end
    endtask

    task automatic push_exp();
        obs_t e;
        for (int i = 0; i < 3; i++) begin
            e.q    = m_q[i];
            e.tick = m_tick[i];
            e.wrap = m_wrap[i];
            e.term = ud ? (m_q[i] == 8'hFF) : (m_q[i] == 8'h00);
            sb.push_back(e);
        end
    endtask

    task automatic compare_all();
        obs_t act[3];
        obs_t e;
        act[0] = {ifa.Q, ifa.tick, ifa.wrap, ifa.terminal};
        act[1] = {ifb.Q, ifb.tick, ifb.wrap, ifb.terminal};
        act[2] = {ifc.Q, ifc.tick, ifc.wrap, ifc.terminal};
        for (int i = 0; i < 3; i++) begin
            if (sb.size() == 0) begin
                chk({nm[i], ".sb_empty"}, 1, 0);
            end else begin
                e = sb.pop_front();
                chk({nm[i], ".Q"},        int'(act[i].q),    int'(e.q));
                chk({nm[i], ".tick"},     int'(act[i].tick), int'(e.tick));
                chk({nm[i], ".wrap"},     int'(act[i].wrap), int'(e.wrap));
                chk({nm[i], ".terminal"}, int'(act[i].term), int'(e.term));
            end
        end
    endtask

    // One clock: drive, predict, then compare 1 time unit after the edge.
    task automatic apply(input logic c, input logic u, input logic l, input logic [7:0] v);
        cnt = c; ud = u; ld = l; lv = v;
        for (int i = 0; i < 3; i++) model_step(i);
        push_exp();
        @(posedge clock);
        #1;
        compare_all();
    endtask

    int ticks, wraps, first;

    initial begin
        n_checks = 0; n_fail = 0;
        clear_n = 1'b0; cnt = 1'b0; ud = 1'b0; ld = 1'b0; lv = 8'h00;
        model_reset();

        // Reset state; terminal follows up_down with Q=0.
        #2; push_exp(); compare_all();
        ud = 1'b1; #1; push_exp(); compare_all();
        clear_n = 1'b1;

        // 40 enabled up edges from reset.
        ticks = 0; wraps = 0; first = 0;
        for (int k = 1; k <= 40; k++) begin
            apply(1'b1, 1'b1, 1'b0, 8'h00);
            if (ifa.tick) begin ticks++; if (first == 0) first = k; end
            if (ifa.wrap) wraps++;
        end
        chk("r031.Q", int'(ifa.Q), 10);
        chk("r031.ticks", ticks, 10);
        chk("r031.first_tick_edge", first, 4);
        chk("r031.wraps", wraps, 0);

        // Wrap through FF->00, then load colliding with a step edge (pre=3).
        tbl[0] = {1'b0, 1'b1, 1'b1, 8'hFE, 8'hFE, 1'b0, 1'b0, 1'b0};
        for (int k = 1; k <= 3; k++)   tbl[k] = {1'b1, 1'b1, 1'b0, 8'h00, 8'hFE, 1'b0, 1'b0, 1'b0};
        tbl[4] = {1'b1, 1'b1, 1'b0, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b1};
        for (int k = 5; k <= 7; k++)   tbl[k] = {1'b1, 1'b1, 1'b0, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b1};
        tbl[8] = {1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0};
        for (int k = 9; k <= 11; k++)  tbl[k] = {1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[12] = {1'b1, 1'b1, 1'b1, 8'h5A, 8'h5A, 1'b0, 1'b0, 1'b0};
        for (int k = 13; k <= 15; k++) tbl[k] = {1'b1, 1'b1, 1'b0, 8'h00, 8'h5A, 1'b0, 1'b0, 1'b0};
        tbl[16] = {1'b1, 1'b1, 1'b0, 8'h00, 8'h5B, 1'b1, 1'b0, 1'b0};
        for (int k = 0; k < 17; k++) begin
            apply(tbl[k].c, tbl[k].u, tbl[k].l, tbl[k].v);
            chk($sformatf("tbl[%0d].Q", k),        int'(ifa.Q),        int'(tbl[k].eq));
            chk($sformatf("tbl[%0d].tick", k),     int'(ifa.tick),     int'(tbl[k].et));
            chk($sformatf("tbl[%0d].wrap", k),     int'(ifa.wrap),     int'(tbl[k].ew));
            chk($sformatf("tbl[%0d].terminal", k), int'(ifa.terminal), int'(tbl[k].eterm));
        end

        // Saturating instance: load 1, count down 12 edges.
        apply(1'b0, 1'b0, 1'b1, 8'h01);
        ticks = 0; wraps = 0;
        for (int k = 1; k <= 12; k++) begin
            apply(1'b1, 1'b0, 1'b0, 8'h00);
            if (ifb.tick) ticks++;
            if (ifb.wrap) wraps++;
        end
        chk("r033.Q", int'(ifb.Q), 0);
        chk("r033.ticks", ticks, 3);
        chk("r033.wraps", wraps, 0);
        chk("r033.terminal", int'(ifb.terminal), 1);

        // Asynchronous clear mid-prescale (pre=2, Q=5), released before the next edge.
        apply(1'b0, 1'b1, 1'b1, 8'h05);
        apply(1'b1, 1'b1, 1'b0, 8'h00);
        apply(1'b1, 1'b1, 1'b0, 8'h00);
        chk("r035.Q_before", int'(ifa.Q), 5);
        #2; clear_n = 1'b0; model_reset();
        #1; push_exp(); compare_all();
        chk("r035.Q_cleared", int'(ifa.Q), 0);
        #1; clear_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            apply(1'b1, 1'b1, 1'b0, 8'h00);
            chk($sformatf("r035.tick_edge%0d", k), int'(ifa.tick), (k == 4) ? 1 : 0);
        end
        chk("r035.Q_after", int'(ifa.Q), 1);

        // Prescale of 1: every enabled edge steps, wrapping through 00.
        apply(1'b0, 1'b1, 1'b1, 8'hFD);
        ticks = 0; wraps = 0;
        for (int k = 1; k <= 5; k++) begin
            apply(1'b1, 1'b1, 1'b0, 8'h00);
            if (ifc.tick) ticks++;
            if (ifc.wrap) begin wraps++; chk("r036.wrap_at_00", int'(ifc.Q), 0); end
        end
        chk("r036.Q", int'(ifc.Q), 2);
        chk("r036.ticks", ticks, 5);
        chk("r036.wraps", wraps, 1);

        // terminal reacts to up_down with no clock edge.
        apply(1'b0, 1'b1, 1'b1, 8'hFF);
        ud = 1'b0; #1; push_exp(); compare_all();
        chk("r024.term_down_at_ff", int'(ifa.terminal), 0);
        ud = 1'b1; #1; push_exp(); compare_all();
        chk("r024.term_up_at_ff", int'(ifa.terminal), 1);

        // Random mix, including direction changes mid-prescale and occasional loads.
        for (int k = 0; k < 300; k++) begin
            apply($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 15) == 0, 8'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/prescaled_counter.md
PRESCALED_COUNTER -- requirements
Module: prescaled_counter

Interface
REQ-001 Parameter WIDTH, default 8: bit width of count value Q and load_value.
REQ-002 Parameter CYCLES_PER_TICK, default 500: enabled clock cycles per count step; legal range >= 1.
REQ-003 Parameter SATURATE, default 0: 0 = wrap at limits, 1 = hold at limits.
REQ-004 The design shall have one clock; reset is asynchronous and active-low; the ports shall be named clock and clear_n.
REQ-005 clock  input  1  sole clock, all state changes on rising edge.
REQ-006 clear_n  input  1  asynchronous active-low reset.
REQ-007 count  input  1  count enable; prescaler advances only while high.
REQ-008 up_down  input  1  direction: 1 = increment, 0 = decrement.
REQ-009 load  input  1  synchronous load strobe.
REQ-010 load_value  input  WIDTH  value written to Q on load.
REQ-011 Q  output  WIDTH  registered count value.
REQ-012 tick  output  1  registered one-cycle pulse marking each count step.
REQ-013 wrap  output  1  registered one-cycle pulse marking a wrap-around step.
REQ-014 terminal  output  1  combinational: Q at limit for current direction.

Function
REQ-015 Internal prescaler pre shall count 0..CYCLES_PER_TICK-1; width max(1, clog2(CYCLES_PER_TICK)).
REQ-016 Step condition: count=1 and pre=CYCLES_PER_TICK-1, with load=0.
REQ-017 On an edge with count=1, load=0 and step condition false, pre shall increment by 1; Q unchanged.
REQ-018 On a step edge, pre shall return to 0, Q shall move one position in the up_down direction, and tick shall be 1 for the following cycle.
REQ-019 With count=0 and load=0, pre and Q shall hold; tick and wrap shall be 0.
REQ-020 CYCLES_PER_TICK=1: every enabled edge shall be a step edge.
REQ-021 Wrap mode (SATURATE=0): up step from all-ones shall give 0; down step from 0 shall give all-ones; wrap=1 for the following cycle on either.
REQ-022 Saturate mode (SATURATE=1): step at the limit shall leave Q unchanged, still pulse tick, never pulse wrap.
REQ-023 load=1 shall take priority over count: Q<=load_value, pre<=0, tick<=0, wrap<=0.
REQ-024 terminal shall be 1 when (up_down=1 and Q=all-ones) or (up_down=0 and Q=0); it shall respond immediately to up_down changes.
REQ-025 A change of up_down mid-prescale shall not reset pre; the next step shall use up_down sampled on the step edge.
REQ-026 tick and wrap shall never be high for more than one consecutive cycle unless consecutive step edges occur (CYCLES_PER_TICK=1).
REQ-027 All arithmetic shall be modulo 2^WIDTH; no carry shall leave the block except through wrap.

Reset
REQ-028 clear_n=0 shall immediately force Q=0, pre=0, tick=0, wrap=0, independent of clock.
REQ-029 Reset asserted mid-prescale shall discard partial progress; after release the first step shall need a full CYCLES_PER_TICK enabled edges.
REQ-030 During reset, terminal shall follow REQ-024 with Q=0 (1 when up_down=0).

Verification (WIDTH=8, CYCLES_PER_TICK=4 unless stated)
REQ-031 Reset, then count=1, up_down=1 for 40 edges -> Q=10, ten tick pulses, first tick in cycle after 4th edge, wrap never set.
REQ-032 load_value=8'hFE with load pulse, then count up for 8 edges -> Q=8'hFF then 8'h00, wrap pulses once with the 8'h00 step, terminal=1 while Q=8'hFF.
REQ-033 SATURATE=1, load 8'h01, count down 12 edges -> Q=8'h00 then held, three tick pulses, wrap never set, terminal=1 at 0.
REQ-034 load=1 and count=1 on the same edge with pre=3 -> Q=load_value, no tick; next step after 4 further enabled edges.
REQ-035 clear_n pulsed low between clock edges with pre=2, Q=5 -> Q=0 at once; after release step requires 4 edges.
REQ-036 CYCLES_PER_TICK=1, count up from 8'hFD for 5 edges -> Q=8'h02, tick high 5 consecutive cycles, wrap single pulse on 8'h00.
